// File: rtl/acc_write_arbiter.sv
// Round-robin arbiter for the accumulator write port: grant in stage A, registered ldacc/acc in stage B.
// Optional write/conflict counters are enabled by defining ACC_WRITE_ARBITER_STATS_EN.
module acc_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               execlk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               acc_hold,
    input  logic               acc_flush,
    output logic [NREQ-1:0]    gnt,
    output logic               ldacc,
    output logic [DW-1:0]      acc,
    output logic               acc_busy,
    output logic [SW-1:0]      last_src
`ifdef ACC_WRITE_ARBITER_STATS_EN
    ,
    output logic [31:0]        wr_count,
    output logic [31:0]        conflict_count
`endif
);

    logic [SW-1:0] ptr_p0;
    logic [SW-1:0] win_p0;
    logic [SW-1:0] ptr_next_p0;
    logic          any_p0;
    logic          grant_en_p0;
    int            idx;

    logic          vld_p1;
    logic [DW-1:0] data_p1;
    logic [SW-1:0] src_p1;

    // Stage A: first set request at or after the pointer, wrapping upward.
    always_comb begin
        any_p0 = 1'b0;
        win_p0 = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_p0) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_p0 && req[idx]) begin
                any_p0 = 1'b1;
                win_p0 = SW'(idx);
            end
        end
    end

    assign grant_en_p0 = any_p0 && !acc_hold && !acc_flush;
    assign ptr_next_p0 = (win_p0 == SW'(NREQ - 1)) ? '0 : win_p0 + SW'(1);
    assign acc_busy    = (|gnt) | ldacc;

    always_ff @(posedge execlk) begin
        if (rst) begin
            gnt      <= '0;
            ptr_p0   <= '0;
            vld_p1   <= 1'b0;
            src_p1   <= '0;
            ldacc    <= 1'b0;
            acc      <= '0;
            last_src <= '0;
        end else begin
            gnt    <= grant_en_p0 ? (NREQ'(1) << win_p0) : '0;
            vld_p1 <= grant_en_p0;
            if (grant_en_p0) begin
                src_p1 <= win_p0;
                ptr_p0 <= ptr_next_p0;
            end
            // Stage B: a flush in the grant cycle squashes the captured write.
            ldacc <= vld_p1 && !acc_flush;
            if (vld_p1 && !acc_flush) begin
                acc      <= data_p1;
                last_src <= src_p1;
            end
        end
    end

    always_ff @(posedge execlk) begin
        if (grant_en_p0) data_p1 <= req_data[win_p0*DW +: DW];
    end

`ifdef ACC_WRITE_ARBITER_STATS_EN
    logic multi_req;
    assign multi_req = (req & (req - NREQ'(1))) != '0;

    always_ff @(posedge execlk) begin
        if (rst) begin
            wr_count       <= '0;
            conflict_count <= '0;
        end else begin
            if (ldacc) wr_count <= wr_count + 32'd1;
            if (multi_req && !acc_hold) conflict_count <= conflict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_write_arbiter.sv
// Bench for acc_write_arbiter: directed scenarios plus random traffic against a queue-free reference model.
// Counter checks are included when ACC_WRITE_ARBITER_STATS_EN is defined.
module tb_acc_write_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int SW   = 2;

    logic               execlk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               acc_hold;
    logic               acc_flush;
    logic [NREQ-1:0]    gnt;
    logic               ldacc;
    logic [DW-1:0]      acc;
    logic               acc_busy;
    logic [SW-1:0]      last_src;
`ifdef ACC_WRITE_ARBITER_STATS_EN
    logic [31:0]        wr_count;
    logic [31:0]        conflict_count;
`endif

    acc_write_arbiter #(.NREQ(NREQ), .DW(DW), .SW(SW)) dut (
        .execlk(execlk), .rst(rst), .req(req), .req_data(req_data),
        .acc_hold(acc_hold), .acc_flush(acc_flush), .gnt(gnt), .ldacc(ldacc),
        .acc(acc), .acc_busy(acc_busy), .last_src(last_src)
`ifdef ACC_WRITE_ARBITER_STATS_EN
        , .wr_count(wr_count), .conflict_count(conflict_count)
`endif
    );

    always #5 execlk = ~execlk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_ptr;
    bit          m_pend;
    int          m_pend_src;
    logic [31:0] m_pend_data;
    int          m_gnt_idx;   // -1 when no grant is showing
    bit          m_ldacc;
    logic [31:0] m_acc;
    int          m_last;
    logic [31:0] m_wr;
    logic [31:0] m_conf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int i);
        logic [NREQ*DW-1:0] d;
        d = req_data;
        return d[i*DW +: DW];
    endfunction

    // Apply the spec rules for one rising edge to the model.
    task automatic model_edge();
        int bits;
        int w;
        if (rst) begin
            m_ptr = 0; m_pend = 0; m_gnt_idx = -1; m_ldacc = 0;
            m_acc = 0; m_last = 0; m_wr = 0; m_conf = 0;
            return;
        end
        if (m_ldacc) m_wr = m_wr + 1;
        bits = 0;
        for (int i = 0; i < NREQ; i++) if (req[i]) bits++;
        if (bits >= 2 && !acc_hold) m_conf = m_conf + 1;
        m_ldacc = m_pend && !acc_flush;
        if (m_ldacc) begin
            m_acc  = m_pend_data;
            m_last = m_pend_src;
        end
        w = -1;
        if (!acc_hold && !acc_flush) begin
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        m_gnt_idx = w;
        m_pend    = (w >= 0);
        if (w >= 0) begin
            m_pend_src  = w;
            m_pend_data = data_of(w);
            m_ptr       = (w + 1) % NREQ;
        end
    endtask

    task automatic compare_model();
        logic [31:0] eg;
        eg = (m_gnt_idx < 0) ? 32'd0 : (32'd1 << m_gnt_idx);
        check("gnt", {29'd0, gnt}, eg);
        check("ldacc", {31'd0, ldacc}, {31'd0, m_ldacc});
        check("acc", acc, m_acc);
        check("last_src", {30'd0, last_src}, m_last);
        check("acc_busy", {31'd0, acc_busy}, {31'd0, (m_gnt_idx >= 0) || m_ldacc});
`ifdef ACC_WRITE_ARBITER_STATS_EN
        check("wr_count", wr_count, m_wr);
        check("conflict_count", conflict_count, m_conf);
`endif
    endtask

    // One clock: inputs already driven; advance model and compare just after the edge.
    task automatic tick();
        @(posedge execlk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic drive(input bit r, input logic [2:0] q, input bit h, input bit f);
        rst = r; req = q; acc_hold = h; acc_flush = f;
    endtask

    task automatic do_reset();
        drive(1, 3'b000, 0, 0);
        tick();
        drive(0, 3'b000, 0, 0);
    endtask

    initial begin
        req_data = '0;
        drive(1, 3'b111, 0, 0);
        @(posedge execlk); #1;

        // 1: reset wins over pending requests
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_gnt", {29'd0, gnt}, 32'd0);
            check("rst_ldacc", {31'd0, ldacc}, 32'd0);
            check("rst_acc", acc, 32'd0);
            check("rst_busy", {31'd0, acc_busy}, 32'd0);
        end
        drive(0, 3'b111, 0, 0);
        tick();
        check("first_gnt", {29'd0, gnt}, 32'h1);

        // 2: single request
        do_reset();
        req_data[1*DW +: DW] = 32'hDEADBEEF;
        drive(0, 3'b010, 0, 0);
        tick();
        check("t2_gnt", {29'd0, gnt}, 32'h2);
        check("t2_busy1", {31'd0, acc_busy}, 32'd1);
        drive(0, 3'b000, 0, 0);
        tick();
        check("t2_ldacc", {31'd0, ldacc}, 32'd1);
        check("t2_acc", acc, 32'hDEADBEEF);
        check("t2_src", {30'd0, last_src}, 32'd1);
        check("t2_busy2", {31'd0, acc_busy}, 32'd1);
        tick();
        check("t2_busy3", {31'd0, acc_busy}, 32'd0);
        check("t2_src_hold", {30'd0, last_src}, 32'd1);

        // 3: round-robin with all three requesting
        do_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'h10 + i;
        drive(0, 3'b111, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 7) drive(0, 3'b000, 0, 0);
            tick();
            if (k <= 6) check("t3_gnt", {29'd0, gnt}, 32'd1 << ((k - 1) % 3));
            if (k >= 2 && k <= 7) begin
                check("t3_ldacc", {31'd0, ldacc}, 32'd1);
                check("t3_acc", acc, 32'h10 + ((k - 2) % 3));
            end
        end
`ifdef ACC_WRITE_ARBITER_STATS_EN
        check("t6_wr", wr_count, 32'd6);
        check("t6_conf", conflict_count, 32'd6);
        do_reset();
        check("t6_wr_rst", wr_count, 32'd0);
        check("t6_conf_rst", conflict_count, 32'd0);
`endif

        // 4: hold blocks grants and freezes the pointer
        do_reset();
        drive(0, 3'b101, 1, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_hold_gnt", {29'd0, gnt}, 32'd0);
            check("t4_hold_ld", {31'd0, ldacc}, 32'd0);
        end
        drive(0, 3'b101, 0, 0);
        tick();
        check("t4_gnt0", {29'd0, gnt}, 32'h1);
        tick();
        check("t4_gnt2", {29'd0, gnt}, 32'h4);
        drive(0, 3'b000, 0, 0);
        tick();
        tick();

        // 5: flush squashes a granted write
        do_reset();
        req_data[0*DW +: DW] = 32'hAAAA5555;
        req_data[1*DW +: DW] = 32'h00001111;
        drive(0, 3'b011, 0, 0);
        tick();
        check("t5_gnt0", {29'd0, gnt}, 32'h1);
        drive(0, 3'b010, 0, 1);
        tick();
        check("t5_flush_gnt", {29'd0, gnt}, 32'd0);
        check("t5_flush_ld", {31'd0, ldacc}, 32'd0);
        check("t5_acc_kept", acc, 32'd0);
        drive(0, 3'b010, 0, 0);
        tick();
        check("t5_gnt1", {29'd0, gnt}, 32'h2);
        check("t5_ld_still0", {31'd0, ldacc}, 32'd0);
        drive(0, 3'b000, 0, 0);
        tick();
        check("t5_ld1", {31'd0, ldacc}, 32'd1);
        check("t5_acc1", acc, 32'h00001111);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
            drive(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/acc_write_arbiter.md
Name: acc_write_arbiter

Overview:
Shares the 32-bit accumulator write port between NREQ execute-stage requesters: ALU result, load data and immediate move by default. Arbitrates round-robin, captures the winner's data, and drives the accumulator's ldacc/acc inputs one cycle later. Sits between the execute units and the accumulator register. Exposes a busy flag so operand readers can stall on a stale acc_out.

Parameters:
NREQ, 3, number of requesters (2..8)
DW, 32, data width, matches accumulator width
SW, $clog2(NREQ) (min 1), width of source-index outputs

Ports:
execlk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset, sampled on execlk rising edge
req  in  NREQ  per-requester write request, level, held until granted
req_data  in  NREQ*DW  requester i data in bits [i*DW +: DW]
acc_hold  in  1  pipeline stall; blocks new grants
acc_flush  in  1  squash; kills the write in flight and blocks grant this cycle
gnt  out  NREQ  one-hot grant pulse, registered
ldacc  out  1  accumulator load enable, registered
acc  out  DW  accumulator write data, registered
acc_busy  out  1  write granted or in flight (gnt!=0 | ldacc)
last_src  out  SW  index of the most recent requester that drove ldacc

Behaviour:
- Reset (rst=1 at edge): gnt=0, ldacc=0, acc=0, acc_busy=0, last_src=0, RR pointer=0, stage-B valid=0. Reset wins over every other input.
- Two-stage pipeline, one write per cycle sustained:
  - Stage A, edge E: if acc_hold=0, acc_flush=0 and any req is set, grant the first set req at or after the pointer, searching upward with wrap.
    - gnt[w]=1 for the cycle after E.
    - Capture req_data[w] and w into stage B.
    - Pointer becomes (w+1) mod NREQ.
    - Otherwise gnt=0 and the pointer is unchanged.
  - Stage B, edge E+1: ldacc=1, acc=captured data, last_src=w for one cycle. The accumulator loads at edge E+2.
- Latency: req sampled at E -> gnt high in cycle E..E+1 -> ldacc high in cycle E+1..E+2 -> acc_out updated after E+2.
- Handshake:
  - A requester keeps req and data stable until it sees gnt[i]=1.
  - It drops req or presents the next data in the cycle after gnt.
  - req falling before grant is legal; that request is not granted.
- Back-to-back: grants on consecutive edges are allowed. ldacc may stay high several cycles with new data each cycle.
- Single requester with req held high gets a grant every cycle.
- acc_hold=1: no new grant; a grant already issued still completes its stage B write. The pointer is frozen.
- acc_flush=1 at edge:
  - Stage-B valid is cleared, so ldacc=0 next cycle even if gnt was high this cycle.
  - No grant is made.
  - The pointer is unchanged, but it has already advanced past the squashed winner.
  - Flush takes priority over hold.
- acc_busy is combinational from the registered gnt and ldacc only. It does not depend on req inputs.
- last_src holds its value when ldacc=0.
- Reset mid-operation: the pending stage-B write is discarded and ldacc=0 after the reset edge.

Optional Feature:
Macro ACC_WRITE_ARBITER_STATS_EN.
- Defined: adds outputs wr_count[31:0] and conflict_count[31:0].
  - wr_count increments on each edge where ldacc=1.
  - conflict_count increments on each edge where 2 or more req bits are set and acc_hold=0.
  - Both counters clear on rst and wrap modulo 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 with req=3'b111 -> gnt=0, ldacc=0, acc=0, acc_busy=0 every cycle. First grant is gnt=3'b001 on the edge after rst falls.
2. Single request: req=3'b010 with data[1]=0xDEADBEEF for one cycle -> next cycle gnt=3'b010; cycle after that ldacc=1, acc=0xDEADBEEF, last_src=1; acc_busy high for exactly 2 cycles.
3. Round-robin: req=3'b111 held 6 cycles, data i = 0x10+i -> gnt sequence 001,010,100,001,010,100; acc sequence 0x10,0x11,0x12,0x10,0x11,0x12 with ldacc high for 6 consecutive cycles.
4. Hold: req=3'b101 with acc_hold=1 for 3 cycles -> gnt=0 and ldacc=0 throughout. On release, gnt=001, then gnt=100.
5. Flush in flight: grant req0 (data 0xAAAA5555), assert acc_flush in the gnt cycle -> ldacc stays 0 and acc_out is unchanged. The next grant goes to req1 if req1 is pending.
6. Stats (macro defined): run scenario 3 -> wr_count=6, conflict_count=6. After rst both counters read 0.
